// File: rtl/nn_layer_engine_if.sv
// Host bus and result bundle for nn_layer_engine.
interface nn_layer_engine_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WIDTH_ADDR = 4,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned WIDTH_O    = 4
) ();

  logic [WIDTH_ADDR-1:0]    address;
  logic [WIDTH-1:0]         in_d;
  logic                     write;
  logic                     read;
  logic [WIDTH-1:0]         out_d;
  logic                     rd_valid;
  logic                     busy;
  logic                     done;
  logic [N_OUT*WIDTH_O-1:0] o_vec;

  modport master (
    output address, in_d, write, read,
    input  out_d, rd_valid, busy, done, o_vec
  );

  modport slave (
    input  address, in_d, write, read,
    output out_d, rd_valid, busy, done, o_vec
  );

endinterface

// File: rtl/nn_layer_engine.sv
// Register-mapped fully connected layer: one MAC evaluates each neuron in turn, then a
// saturating hard-sigmoid maps the accumulator onto the unsigned output range.
module nn_layer_engine #(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned N_OUT      = 2,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WIDTH_W    = 4,
  parameter int unsigned WIDTH_I    = 4,
  parameter int unsigned WIDTH_O    = 4,
  parameter int unsigned WIDTH_ADDR = $clog2(N_IN*N_OUT+2*N_OUT+N_IN+2)
) (
  input logic              clk,
  input logic              reset,
  nn_layer_engine_if.slave bus
);

  localparam int unsigned NW        = N_IN * N_OUT;
  localparam int unsigned ADDR_BIAS = NW;
  localparam int unsigned ADDR_IN   = NW + N_OUT;
  localparam int unsigned ADDR_CTRL = ADDR_IN + N_IN;
  localparam int unsigned ADDR_STAT = ADDR_CTRL + 1;
  localparam int unsigned ADDR_OUT  = ADDR_CTRL + 2;
  localparam int unsigned ACC_W     = WIDTH_W + WIDTH_I + 2 + $clog2(N_IN + 1);
  localparam int unsigned IW        = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW        = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [IW-1:0]           I_LAST   = IW'(N_IN - 1);
  localparam logic [JW-1:0]           J_LAST   = JW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] OUT_HALF = ACC_W'(2 ** (WIDTH_O - 1));
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'(2 ** WIDTH_O - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StMac, StAct, StFin} state_e;

  state_e r_state, w_state_d;

  logic [WIDTH_W-1:0] r_weight [NW];
  logic [WIDTH_W-1:0] r_bias   [N_OUT];
  logic [WIDTH_I-1:0] r_input  [N_IN];
  logic [WIDTH_O-1:0] r_out    [N_OUT];

  logic signed [ACC_W-1:0] r_acc;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  logic                    r_err, r_valid, r_done;
  logic [WIDTH-1:0]        r_out_d;
  logic                    r_rd_valid;

  int unsigned             w_addr, w_widx;
  logic                    w_busy, w_start, w_err_set, w_err_clr;
  logic [WIDTH_W-1:0]      w_weight_sel, w_bias_sel;
  logic [WIDTH_I-1:0]      w_input_sel;
  logic signed [ACC_W-1:0] w_prod, w_biased;
  logic [WIDTH_O-1:0]      w_sat;
  logic [WIDTH-1:0]        w_rd_data;
  logic                    w_unused_in;

  assign w_addr      = 32'(bus.address);
  assign w_busy      = (r_state != StIdle);
  assign w_start     = bus.write && !w_busy && (w_addr == ADDR_CTRL) && bus.in_d[0];
  // Any data-register write or start request while running is refused and flagged.
  assign w_err_set   = bus.write && w_busy &&
                       ((w_addr < ADDR_CTRL) || ((w_addr == ADDR_CTRL) && bus.in_d[0]));
  assign w_err_clr   = bus.write && (w_addr == ADDR_CTRL) && bus.in_d[1];
  assign w_unused_in = ^bus.in_d;

  // Operand selection for the current neuron j and input i.
  assign w_widx = 32'(r_j) * N_IN + 32'(r_i);
  always_comb begin
    w_weight_sel = '0;
    w_bias_sel   = '0;
    w_input_sel  = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (w_widx == k) w_weight_sel = r_weight[k];
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(r_j) == k) w_bias_sel = r_bias[k];
    end
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (32'(r_i) == k) w_input_sel = r_input[k];
    end
  end

  // Signed weight times unsigned input, both widened to the accumulator first.
  assign w_prod   = $signed(ACC_W'($signed(w_weight_sel))) * $signed(ACC_W'(w_input_sel));
  assign w_biased = r_acc + OUT_HALF;

  // Hard-sigmoid: shift to mid-range, clamp to [0, 2**WIDTH_O-1].
  always_comb begin
    w_sat = w_biased[WIDTH_O-1:0];
    if (w_biased[ACC_W-1]) begin
      w_sat = '0;
    end else if (w_biased > OUT_MAX) begin
      w_sat = '1;
    end
  end

  // Host writes into weight, bias and input registers, only while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NW; k++) r_weight[k] <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) r_bias[k] <= '0;
      for (int unsigned k = 0; k < N_IN; k++) r_input[k] <= '0;
    end else if (bus.write && !w_busy) begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (w_addr == k) r_weight[k] <= bus.in_d[WIDTH_W-1:0];
      end
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (w_addr == ADDR_BIAS + k) r_bias[k] <= bus.in_d[WIDTH_W-1:0];
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (w_addr == ADDR_IN + k) r_input[k] <= bus.in_d[WIDTH_I-1:0];
      end
    end
  end

  // Sticky error, result-valid flag and end-of-run pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == StFin);
      if (w_start) begin
        r_valid <= 1'b0;
      end else if (r_state == StFin) begin
        r_valid <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state: LOAD bias, N_IN MAC steps, ACT, repeat per neuron, then FIN.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StLoad;
      StLoad:  w_state_d = StMac;
      StMac:   if (r_i == I_LAST) w_state_d = StAct;
      StAct:   w_state_d = (r_j == J_LAST) ? StFin : StLoad;
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: accumulator, loop indices and neuron output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (w_start) r_j <= '0;
        StLoad: begin
          r_acc <= ACC_W'($signed(w_bias_sel));
          r_i   <= '0;
        end
        StMac: begin
          r_acc <= r_acc + w_prod;
          r_i   <= r_i + IW'(1);
        end
        StAct: begin
          for (int unsigned k = 0; k < N_OUT; k++) begin
            if (32'(r_j) == k) r_out[k] <= w_sat;
          end
          if (r_j != J_LAST) r_j <= r_j + JW'(1);
        end
        default: ;
      endcase
    end
  end

  // Read mux; signed registers sign-extend, unsigned ones zero-extend.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (w_addr == k) w_rd_data = WIDTH'($signed(r_weight[k]));
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (w_addr == ADDR_BIAS + k) w_rd_data = WIDTH'($signed(r_bias[k]));
      if (w_addr == ADDR_OUT + k)  w_rd_data = WIDTH'(r_out[k]);
    end
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (w_addr == ADDR_IN + k) w_rd_data = WIDTH'(r_input[k]);
    end
    if (w_addr == ADDR_STAT) w_rd_data = WIDTH'({r_valid, r_err, w_busy});
  end

  // Registered read port; sees register contents from before any same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_d    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.read;
      if (bus.read) r_out_d <= w_rd_data;
    end
  end

  // Parallel result vector follows the output registers.
  always_comb begin
    bus.o_vec = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      bus.o_vec[k*WIDTH_O +: WIDTH_O] = r_out[k];
    end
  end

  assign bus.out_d    = r_out_d;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Bench for nn_layer_engine: transaction-level model checked every cycle plus directed
// literal expectations.
module tb_nn_layer_engine;

  localparam int unsigned N_IN = 2, N_OUT = 2, WIDTH = 8, WIDTH_O = 4, WIDTH_ADDR = 4;
  localparam int unsigned A_BIAS = 4, A_IN = 6, A_CTRL = 8, A_STAT = 9, A_OUT = 10;
  localparam int unsigned LAT = N_OUT * (N_IN + 2) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  nn_layer_engine_if #(.WIDTH(WIDTH), .WIDTH_ADDR(WIDTH_ADDR), .N_OUT(N_OUT),
                       .WIDTH_O(WIDTH_O)) bus ();

  nn_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .WIDTH_W(4), .WIDTH_I(4),
                    .WIDTH_O(WIDTH_O), .WIDTH_ADDR(WIDTH_ADDR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, run timing by edge count, results by arithmetic.
  int   m_w [4];
  int   m_b [2];
  int   m_in [2];
  int   m_out [2];
  int   m_res [2];
  int   m_k;
  bit   m_err, m_valid, m_running, m_done, m_rd_valid, m_ready;
  logic [7:0] m_rd_data;

  function automatic int sat_fn(input int v);
    if (v < 0) return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  function logic [7:0] m_read(input int unsigned a);
    if (a < A_BIAS) return 8'(m_w[a]);
    if (a < A_IN) return 8'(m_b[a - A_BIAS]);
    if (a < A_CTRL) return 8'(m_in[a - A_IN]);
    if (a == A_STAT) return {5'b0, m_valid, m_err, m_running};
    if (a == A_OUT || a == A_OUT + 1) return 8'(m_out[a - A_OUT]);
    return 8'h00;
  endfunction

  function logic [7:0] m_pack();
    return {4'(m_out[1]), 4'(m_out[0])};
  endfunction

  always @(posedge clk) begin : model
    bit          pre;
    int unsigned a;
    int          s;
    logic [7:0]  d;
    m_done = 1'b0;
    if (!reset) begin
      for (int k = 0; k < 4; k++) m_w[k] = 0;
      for (int k = 0; k < 2; k++) begin
        m_b[k] = 0; m_in[k] = 0; m_out[k] = 0;
      end
      m_err = 0; m_valid = 0; m_running = 0; m_rd_valid = 0; m_rd_data = '0; m_k = 0;
      m_ready = 1;
    end else begin
      pre = m_running;
      a   = 32'(bus.address);
      d   = bus.in_d;
      m_rd_valid = bus.read;
      if (bus.read) m_rd_data = m_read(a);
      if (bus.write) begin
        if (a < A_CTRL) begin
          if (pre) m_err = 1;
          else if (a < A_BIAS) m_w[a] = int'($signed(d[3:0]));
          else if (a < A_IN) m_b[a - A_BIAS] = int'($signed(d[3:0]));
          else m_in[a - A_IN] = int'(d[3:0]);
        end else if (a == A_CTRL) begin
          if (d[1]) m_err = 0;
          if (d[0]) begin
            if (pre) m_err = 1;
            else begin
              m_running = 1; m_k = 0; m_valid = 0;
              for (int j = 0; j < 2; j++) begin
                s = m_b[j] + 8;
                for (int i = 0; i < 2; i++) s += m_w[j*2 + i] * m_in[i];
                m_res[j] = sat_fn(s);
              end
            end
          end
        end
      end
      if (pre) begin
        m_k++;
        for (int j = 0; j < 2; j++) if (m_k == (j + 1) * (N_IN + 2)) m_out[j] = m_res[j];
        if (m_k == LAT) begin
          m_running = 0; m_done = 1; m_valid = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("busy", 32'(bus.busy), 32'(m_running));
      check("done", 32'(bus.done), 32'(m_done));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      if (m_rd_valid) check("out_d", 32'(bus.out_d), 32'(m_rd_data));
      check("o_vec", 32'(bus.o_vec), 32'(m_pack()));
    end
  end

  task automatic wr(input int unsigned a, input logic [7:0] d);
    @(negedge clk);
    bus.address = 4'(a); bus.in_d = d; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input int unsigned a, output logic [7:0] d);
    @(negedge clk);
    bus.address = 4'(a); bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    @(negedge clk);
    d = bus.out_d;
    check("rd_valid_pulse", 32'(bus.rd_valid), 32'd1);
  endtask

  task automatic load(input logic [7:0] w0, w1, w2, w3, b0, b1, i0, i1);
    wr(0, w0); wr(1, w1); wr(2, w2); wr(3, w3);
    wr(A_BIAS, b0); wr(A_BIAS + 1, b1); wr(A_IN, i0); wr(A_IN + 1, i1);
  endtask

  // Edges counted from the start edge until done is seen; -1 when the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] r;
    int         n;
    bit         saw_done;
    bus.address = '0; bus.in_d = '0; bus.read = 1'b0;
    // Reset held for three edges while writes are attempted.
    bus.write = 1'b1;
    bus.address = 4'($urandom_range(0, 15)); bus.in_d = 8'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      bus.address = 4'($urandom_range(0, 15)); bus.in_d = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b1; bus.write = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(a, r);
      check($sformatf("reset_rd_%0d", a), 32'(r), 32'h0);
    end
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_ovec", 32'(bus.o_vec), 32'h0);

    // Nominal run: neuron0 = 0+1*3+2*1 = 5 -> 13, neuron1 = -2-3+3 = -2 -> 6.
    load(8'h1, 8'h2, 8'hF, 8'h3, 8'h0, 8'hE, 8'h3, 8'h1);
    wr(A_CTRL, 8'h1);
    wait_done(n);
    check("latency", 32'(n), 32'd9);
    check("nominal_ovec", 32'(bus.o_vec), 32'h6D);
    rd(A_OUT, r);     check("nominal_out0", 32'(r), 32'd13);
    rd(A_OUT + 1, r); check("nominal_out1", 32'(r), 32'd6);
    rd(A_STAT, r);    check("nominal_status", 32'(r), 32'h4);

    // Readback timing and extension.
    rd(2, r);
    check("sext_weight", 32'(r), 32'hFF);
    @(negedge clk);
    check("rd_valid_drop", 32'(bus.rd_valid), 32'd0);
    rd(13, r);        check("unmapped_rd", 32'(r), 32'h0);
    rd(A_BIAS + 1, r); check("sext_bias", 32'(r), 32'hFE);

    // Saturation high and low.
    load(8'h7, 8'h7, 8'h7, 8'h7, 8'h7, 8'h7, 8'hF, 8'hF);
    wr(A_CTRL, 8'h1);
    wait_done(n);
    check("sat_hi_seen", 32'(n), 32'd9);
    check("sat_hi_ovec", 32'(bus.o_vec), 32'hFF);
    load(8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'h8, 8'hF, 8'hF);
    wr(A_CTRL, 8'h1);
    wait_done(n);
    check("sat_lo_seen", 32'(n), 32'd9);
    check("sat_lo_ovec", 32'(bus.o_vec), 32'h00);

    // Write while busy is refused and flags err.
    load(8'h1, 8'h2, 8'hF, 8'h3, 8'h0, 8'hE, 8'h3, 8'h1);
    wr(A_CTRL, 8'h1);
    @(posedge clk);
    wr(A_IN, 8'h9);
    rd(A_STAT, r);
    check("busy_status", 32'(r), 32'h3);
    wait_done(n);
    check("busy_done_seen", 32'(n > 0), 32'd1);
    check("busy_ovec", 32'(bus.o_vec), 32'h6D);
    rd(A_IN, r);      check("busy_input_kept", 32'(r), 32'd3);
    wr(A_CTRL, 8'h2);
    rd(A_STAT, r);    check("err_cleared", 32'(r), 32'h4);

    // Reset four edges after the start aborts the run.
    wr(A_CTRL, 8'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ovec", 32'(bus.o_vec), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd(a, r);
      check($sformatf("abort_rd_%0d", a), 32'(r), 32'h0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_layer_engine.md
Name: nn_layer_engine

Overview:
- Parametrised successor of the network manager: a register-mapped, fully connected neural layer with N_IN inputs and N_OUT neurons.
- Host loads signed weights, biases and unsigned inputs over the address/in_d/write/read bus, then starts a run through CTRL.
- A sequential single-MAC engine evaluates each neuron and applies a saturating hard-sigmoid. Results are readable over the bus and also driven on a parallel output vector, which feeds the next layer.

Parameters:
- N_IN, 2, inputs per neuron.
- N_OUT, 2, neuron count.
- WIDTH, 8, data bus width (must be >= WIDTH_W, WIDTH_I, WIDTH_O, 3).
- WIDTH_W, 4, signed weight and bias width.
- WIDTH_I, 4, unsigned input width.
- WIDTH_O, 4, unsigned output width (sigmoid range 2**WIDTH_O).
- WIDTH_ADDR, $clog2(N_IN*N_OUT+2*N_OUT+N_IN+2), address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- address  in  WIDTH_ADDR  register address.
- in_d  in  WIDTH  write data.
- write  in  1  write strobe, one word per cycle.
- read  in  1  read strobe.
- out_d  out  WIDTH  read data, registered.
- rd_valid  out  1  out_d valid, one-cycle pulse.
- busy  out  1  engine running.
- done  out  1  one-cycle pulse at end of run.
- o_vec  out  N_OUT*WIDTH_O  packed neuron outputs, neuron j at [j*WIDTH_O +: WIDTH_O].

Behaviour:
- Reset (reset==0 at a clk edge):
  - All weights, biases, inputs and outputs cleared to 0.
  - out_d=0, rd_valid=0, busy=0, done=0, err=0, valid=0; FSM returns to IDLE.
  - Applies mid-run as well; the run is aborted.
- Address map (W=N_IN*N_OUT):
  - Weight j,i at j*N_IN+i.
  - Bias j at W+j.
  - Input i at W+N_OUT+i.
  - CTRL at W+N_OUT+N_IN.
  - STATUS at CTRL+1.
  - Output j at CTRL+2+j.
- Writes:
  - Each write stores in_d low bits into the target register.
  - Writes to STATUS, outputs or unmapped addresses are ignored.
  - CTRL write:
    - bit0=1 starts a run.
    - bit1=1 clears err.
    - If both are set, err is cleared and the run starts.
- Reads:
  - out_d and rd_valid are registered; data appears one cycle after the read strobe.
  - Weights and biases are sign-extended to WIDTH. Inputs and outputs are zero-extended.
  - STATUS = {0.., valid, err, busy} in bits [2:0].
  - CTRL and unmapped addresses read 0.
  - Simultaneous read and write to the same address returns the old value.
- While busy:
  - Writes to weights, biases or inputs are ignored and set sticky err.
  - A CTRL start is ignored and sets err; a CTRL clear (bit1) is honoured.
  - Reads are always allowed. Output registers read their previous values until updated.
- FSM states: IDLE, LOAD, MAC, ACT, FIN.
  - IDLE -> LOAD on an accepted start. The start clears valid and sets neuron index j=0.
  - LOAD: acc <= sign-extended bias[j]; i=0; one cycle.
  - MAC: acc <= acc + weight[j][i]*input[i] (signed x unsigned), one product per cycle, N_IN cycles.
  - ACT: out[j] <= sat(acc + 2**(WIDTH_O-1), 0, 2**WIDTH_O-1). Then go to LOAD with j+1 if j<N_OUT-1, else FIN.
  - FIN: done=1 for one cycle, valid<=1, then IDLE.
- busy is 1 in every state except IDLE.
- Accumulator width is WIDTH_W+WIDTH_I+2+$clog2(N_IN+1), so it cannot overflow.
- Latency: done is high in the cycle beginning N_OUT*(N_IN+2)+1 clk edges after the edge that samples the start write. With defaults this is 9.
- o_vec tracks the output registers directly; each neuron slice updates on its ACT edge.
- Inputs changed after a run do not alter outputs until the next run.

Test Plan:
- Reset and idle:
  - Hold reset=0 for 3 cycles with write=1 and random data.
  - Then read every address -> all read 0, busy=0, done=0, o_vec=0.
- Nominal run (defaults):
  - Write W0..3 = 1, 2, 0xF(-1), 3; B4 = 0; B5 = 0xE(-2); I6 = 3; I7 = 1; CTRL8 = 1.
  - Required: done exactly 9 cycles after the start edge.
  - Required: o_vec = {4'd6, 4'd13}; reading addr 10 gives 13, addr 11 gives 6, addr 9 gives 3'b100.
- Saturation:
  - Weights all 7, biases 7, inputs 15 -> both outputs 15.
  - Weights all 0x8, biases 0x8, inputs 15 -> both outputs 0.
- Write during busy:
  - Write I6=9 two cycles after start -> input unchanged, err set, STATUS=3'b011 while running.
  - Outputs match the nominal run.
  - CTRL=2 after done -> STATUS=3'b100.
- Reset mid-run:
  - Drive reset=0 four cycles after start -> busy=0 next edge; done never pulses; all registers 0.
- Readback timing and sign extension:
  - read of addr 2 holding 0xF -> out_d=8'hFF with rd_valid exactly one cycle later.
  - read of unmapped addr 13 -> out_d=0, rd_valid=1.
